// File: rtl/log2_seq_pkg.sv
// rtl/log2_seq_pkg.sv - shared widths and state encoding for the log2 unit
package log2_seq_pkg;

    localparam int OP_W   = 8;
    localparam int EXP_W  = 3;
    localparam int MANT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/log2_seq_lead_one_det.sv
// rtl/log2_seq_lead_one_det.sv - 8-bit leading-one priority encoder
module lead_one_det
    import log2_seq_pkg::*;
(
    input  logic [OP_W-1:0]  data,
    output logic [EXP_W-1:0] exp,
    output logic             zero
);

    // Scan upward so the highest set bit wins.
    always_comb begin
        exp  = '0;
        zero = (data == '0);
        for (int i = 0; i < OP_W; i++) begin
            if (data[i]) begin
                exp = EXP_W'(i);
            end
        end
    end

endmodule

// File: rtl/log2_seq.sv
// rtl/log2_seq.sv - sequential fixed-point log2 by repeated mantissa squaring
module log2_seq
    import log2_seq_pkg::*;
#(
    parameter int FRAC_BITS = 4,
    parameter int CNT_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OP_W-1:0]          in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+FRAC_BITS-1:0] out_log,
    output logic                     out_err
);

    state_t                 state;
    logic [OP_W-1:0]        x_reg;
    logic [MANT_W-1:0]      m_reg;
    logic [EXP_W-1:0]       exp_reg;
    logic [FRAC_BITS-1:0]   frac;
    logic [CNT_W-1:0]       cnt;

    logic [EXP_W-1:0]       lod_exp;
    logic                   lod_zero;
    logic [2*MANT_W-1:0]    sq;
    logic [FRAC_BITS-1:0]   frac_shift;
    logic [MANT_W-1:0]      m_next;

    lead_one_det u_lod (
        .data (x_reg),
        .exp  (lod_exp),
        .zero (lod_zero)
    );

    // Square the 1.7 mantissa; a product >= 2 yields a 1 bit and is renormalised by one extra shift.
    always_comb begin
        sq         = (2*MANT_W)'(m_reg) * (2*MANT_W)'(m_reg);
        frac_shift = (frac << 1) | FRAC_BITS'(sq[2*MANT_W-1]);
        m_next     = sq[2*MANT_W-1] ? sq[2*MANT_W-1:MANT_W] : sq[2*MANT_W-2:MANT_W-1];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_log   <= '0;
            x_reg     <= '0;
            m_reg     <= '0;
            exp_reg   <= '0;
            frac      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg    <= in_data;
                        in_ready <= 1'b0;
                        state    <= NORM;
                    end
                end
                NORM: begin
                    if (lod_zero) begin
                        out_err   <= 1'b1;
                        out_log   <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        m_reg   <= x_reg << (EXP_W'(OP_W - 1) - lod_exp);
                        exp_reg <= lod_exp;
                        frac    <= '0;
                        cnt     <= '0;
                        state   <= ITER;
                    end
                end
                ITER: begin
                    m_reg <= m_next;
                    frac  <= frac_shift;
                    if (cnt == CNT_W'(FRAC_BITS - 1)) begin
                        out_log   <= {exp_reg, frac_shift};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_log2_seq.sv
// tb/tb_log2_seq.sv - self-checking bench for log2_seq
module tb_log2_seq;

    localparam int F = 4;
    localparam int L = 3 + F;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         out_valid;
    logic         out_ready;
    logic [L-1:0] out_log;
    logic         out_err;

    int total = 0;
    int bad   = 0;

    log2_seq #(.FRAC_BITS(F), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_log   (out_log),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   din;
        logic [L-1:0] exp_log;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference: integer exponent from the highest power of two, then fraction bits by squaring the mantissa.
    function automatic int ref_log(input int v);
        int e, m, f;
        if (v == 0) return 0;
        e = 0;
        for (int i = 0; i < 8; i++) if (v >= (1 << i)) e = i;
        m = v * (1 << (7 - e));
        f = 0;
        for (int k = 0; k < F; k++) begin
            m = m * m;
            if (m >= 32768) begin
                f = f * 2 + 1;
                m = m / 256;
            end else begin
                f = f * 2;
                m = m / 128;
            end
        end
        return e * (1 << F) + f;
    endfunction

    // Issue one operand, measure cycles to out_valid, optionally hold back-pressure and check stability.
    task automatic run_op(input logic [7:0] d, input int hold, input string tag,
                          output int lat, output int lg, output int er);
        int w;
        @(negedge clk);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk({tag, "_in_ready_timeout"}, 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        lg = int'(out_log);
        er = int'(out_err);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = 8'h55;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({tag, "_bp_valid"}, int'(out_valid), 1);
                chk({tag, "_bp_log"}, int'(out_log), lg);
                chk({tag, "_bp_in_ready"}, int'(in_ready), 0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            chk({tag, "_bp_release_valid"}, int'(out_valid), 0);
            chk({tag, "_bp_release_in_ready"}, int'(in_ready), 1);
        end
    endtask

    vec_t vecs[$];
    int   lat, lg, er;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_out_log", int'(out_log), 0);
        rst = 1'b0;

        vecs.push_back('{8'h01, 7'h00, 1'b0, F + 2});
        vecs.push_back('{8'h03, 7'h19, 1'b0, F + 2});
        vecs.push_back('{8'hFF, 7'h7F, 1'b0, F + 2});
        vecs.push_back('{8'h80, 7'h70, 1'b0, F + 2});
        vecs.push_back('{8'h00, 7'h00, 1'b1, 2});
        vecs.push_back('{8'h02, 7'h10, 1'b0, F + 2});

        foreach (vecs[i]) begin
            run_op(vecs[i].din, 0, $sformatf("vec%0d", i), lat, lg, er);
            chk($sformatf("vec%0d_log", i), lg, int'(vecs[i].exp_log));
            chk($sformatf("vec%0d_err", i), er, int'(vecs[i].exp_err));
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        run_op(8'h03, 5, "bp", lat, lg, er);
        chk("bp_log", lg, 'h19);
        chk("bp_lat", lat, F + 2);

        @(negedge clk);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        run_op(8'h02, 0, "after_abort", lat, lg, er);
        chk("after_abort_log", lg, 'h10);
        chk("after_abort_err", er, 0);
        chk("after_abort_lat", lat, F + 2);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            int         h;
            d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            h = $urandom_range(0, 2);
            run_op(d, h, $sformatf("rnd%0d", n), lat, lg, er);
            chk($sformatf("rnd%0d_log_d%0h", n, d), lg, ref_log(int'(d)));
            chk($sformatf("rnd%0d_err_d%0h", n, d), er, (d == 8'h00) ? 1 : 0);
            chk($sformatf("rnd%0d_lat_d%0h", n, d), lat, (d == 8'h00) ? 2 : F + 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
